// File: rtl/retire_pkg.sv
// Shared types for the in-order retirement stage: FSM states, register index types
// and the per-slot ROB head record.
package retire_pkg;

  localparam int ARCH_REGS_DEF = 64;
  localparam int PHYS_REGS_DEF = 128;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, HALTED} retire_state_e;

  typedef logic [$clog2(ARCH_REGS_DEF)-1:0] arch_idx_t;
  typedef logic [$clog2(PHYS_REGS_DEF)-1:0] phys_idx_t;

  typedef struct packed {
    logic      valid;
    logic      complete;
    logic      has_dest;
    arch_idx_t arch;
    phys_idx_t phys;
    phys_idx_t old_phys;
    logic      mispred;
    logic      halt;
  } rob_head_t;

endpackage

// File: rtl/retire_select.sv
// Combinational retire-prefix selection: the oldest contiguous run of completed slots,
// cut after the first mispredicted branch or halt.
module retire_select #(
  parameter int W  = 1,
  parameter int PW = $clog2(W + 1)
) (
  input  logic          run_i,
  input  logic [W-1:0]  valid_i,
  input  logic [W-1:0]  complete_i,
  input  logic [W-1:0]  mispred_i,
  input  logic [W-1:0]  halt_i,
  output logic [W-1:0]  retire_o,
  output logic [PW-1:0] pop_cnt_o,
  output logic          stop_mispred_o,
  output logic          stop_halt_o
);

  logic open_c;

  // Only the last retiring slot can carry a stop flag, so at most one of the
  // stop outputs is set; mispred is tested first and wins over halt.
  always_comb begin
    retire_o       = '0;
    pop_cnt_o      = '0;
    stop_mispred_o = 1'b0;
    stop_halt_o    = 1'b0;
    open_c         = run_i;
    for (int i = 0; i < W; i++) begin
      if (open_c && valid_i[i] && complete_i[i]) begin
        retire_o[i] = 1'b1;
        pop_cnt_o   = pop_cnt_o + PW'(1);
        if (mispred_i[i]) begin
          stop_mispred_o = 1'b1;
          open_c         = 1'b0;
        end else if (halt_i[i]) begin
          stop_halt_o = 1'b1;
          open_c      = 1'b0;
        end
      end else begin
        open_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_unit.sv
// In-order retirement stage: pops completed ROB head entries, drives AMT commits and
// free-list releases, and sequences DRAIN/FLUSH recovery after a mispredicted branch.
module retire_unit
  import retire_pkg::*;
#(
  parameter int ARCH_REGS    = 64,
  parameter int PHYS_REGS    = 128,
  parameter int COMMIT_WIDTH = 1,
  parameter int CNT_W        = 32,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [COMMIT_WIDTH-1:0]          rob_valid_i,
  input  logic [COMMIT_WIDTH-1:0]          rob_complete_i,
  input  logic [COMMIT_WIDTH-1:0]          rob_has_dest_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]  rob_arch_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  rob_phys_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  rob_old_phys_i,
  input  logic [COMMIT_WIDTH-1:0]          rob_mispred_i,
  input  logic [COMMIT_WIDTH-1:0]          rob_halt_i,
  output logic [CW-1:0]                    rob_pop_cnt_o,
  output logic [COMMIT_WIDTH-1:0]          commit_valid_o,
  output logic [COMMIT_WIDTH-1:0][AW-1:0]  commit_arch_o,
  output logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_phys_o,
  output logic [COMMIT_WIDTH-1:0]          free_valid_o,
  output logic [COMMIT_WIDTH-1:0][PW-1:0]  free_phys_o,
  output logic                             flush_o,
  output logic                             halt_o,
  output logic [CNT_W-1:0]                 retired_count_o
);

  retire_state_e state_q, state_d;

  logic [COMMIT_WIDTH-1:0]         retire;
  logic [CW-1:0]                   pop_cnt;
  logic                            stop_mispred, stop_halt;
  logic                            run;

  logic [COMMIT_WIDTH-1:0]         commit_valid_q, commit_valid_d;
  logic [COMMIT_WIDTH-1:0][AW-1:0] commit_arch_q, commit_arch_d;
  logic [COMMIT_WIDTH-1:0][PW-1:0] commit_phys_q, commit_phys_d;
  logic [COMMIT_WIDTH-1:0]         free_valid_q, free_valid_d;
  logic [COMMIT_WIDTH-1:0][PW-1:0] free_phys_q, free_phys_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  // Reset gates selection so the ROB never sees a pop while reset is held.
  assign run = (state_q == RUN) && !reset;

  retire_select #(.W(COMMIT_WIDTH), .PW(CW)) u_select (
    .run_i          (run),
    .valid_i        (rob_valid_i),
    .complete_i     (rob_complete_i),
    .mispred_i      (rob_mispred_i),
    .halt_i         (rob_halt_i),
    .retire_o       (retire),
    .pop_cnt_o      (pop_cnt),
    .stop_mispred_o (stop_mispred),
    .stop_halt_o    (stop_halt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (stop_mispred)   state_d = DRAIN;
        else if (stop_halt) state_d = HALTED;
      end
      DRAIN:   state_d = FLUSH;
      FLUSH:   state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Data lanes are copied unconditionally; only the valid bits qualify them.
  always_comb begin
    commit_valid_d = retire & rob_has_dest_i;
    commit_arch_d  = rob_arch_i;
    commit_phys_d  = rob_phys_i;
    free_valid_d   = retire & rob_has_dest_i;
    free_phys_d    = rob_old_phys_i;
    cnt_d          = cnt_q + CNT_W'(pop_cnt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      commit_valid_q <= '0;
      commit_arch_q  <= '0;
      commit_phys_q  <= '0;
      free_valid_q   <= '0;
      free_phys_q    <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      commit_valid_q <= commit_valid_d;
      commit_arch_q  <= commit_arch_d;
      commit_phys_q  <= commit_phys_d;
      free_valid_q   <= free_valid_d;
      free_phys_q    <= free_phys_d;
      cnt_q          <= cnt_d;
    end
  end

  assign rob_pop_cnt_o   = pop_cnt;
  assign commit_valid_o  = commit_valid_q;
  assign commit_arch_o   = commit_arch_q;
  assign commit_phys_o   = commit_phys_q;
  assign free_valid_o    = free_valid_q;
  assign free_phys_o     = free_phys_q;
  assign flush_o         = (state_q == FLUSH);
  assign halt_o          = (state_q == HALTED);
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit (W=2, 6-bit counter): directed table, recovery/halt/reset
// sequences, and random traffic against a cycle-level reference model.
module tb_retire_unit;

  localparam int W     = 2;
  localparam int AW    = 6;
  localparam int PWD   = 7;
  localparam int CNT_W = 6;
  localparam int AV    = W * AW;
  localparam int PV    = W * PWD;

  logic clock = 1'b0;
  logic reset;
  logic [W-1:0]          valid, complete, has_dest, mispred, halt;
  logic [W-1:0][AW-1:0]  arch;
  logic [W-1:0][PWD-1:0] phys, old_phys;
  logic [1:0]            pop;
  logic [W-1:0]          commit_valid, free_valid;
  logic [W-1:0][AW-1:0]  commit_arch;
  logic [W-1:0][PWD-1:0] commit_phys, free_phys;
  logic                  flush, halted;
  logic [CNT_W-1:0]      count;

  retire_unit #(.ARCH_REGS(64), .PHYS_REGS(128), .COMMIT_WIDTH(W), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .rob_valid_i     (valid),
    .rob_complete_i  (complete),
    .rob_has_dest_i  (has_dest),
    .rob_arch_i      (arch),
    .rob_phys_i      (phys),
    .rob_old_phys_i  (old_phys),
    .rob_mispred_i   (mispred),
    .rob_halt_i      (halt),
    .rob_pop_cnt_o   (pop),
    .commit_valid_o  (commit_valid),
    .commit_arch_o   (commit_arch),
    .commit_phys_o   (commit_phys),
    .free_valid_o    (free_valid),
    .free_phys_o     (free_phys),
    .flush_o         (flush),
    .halt_o          (halted),
    .retired_count_o (count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles of recovery left (2 = draining, 1 = flushing), halt flag, count.
  int                    m_recov  = 0;
  bit                    m_halted = 1'b0;
  int                    m_cnt    = 0;
  logic [W-1:0]          e_cv     = '0;
  logic [W-1:0][AW-1:0]  e_arch;
  logic [W-1:0][PWD-1:0] e_phys, e_old;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pop(input logic [W-1:0] v, c, mp, hl);
    int n = 0;
    if (m_halted || m_recov != 0) return 0;
    for (int i = 0; i < W; i++) begin
      if (!(v[i] && c[i])) break;
      n++;
      if (mp[i] || hl[i]) break;
    end
    return n;
  endfunction

  // Drive one cycle of head contents, check pop before the edge and registered outputs after.
  task automatic cycle(input logic rst, input logic [W-1:0] v, c, hd, mp, hl,
                       input logic [W-1:0][AW-1:0] a, input logic [W-1:0][PWD-1:0] p, op,
                       output int got_pop);
    int ep;
    reset = rst; valid = v; complete = c; has_dest = hd; mispred = mp; halt = hl;
    arch = a; phys = p; old_phys = op;
    #1;
    ep = rst ? 0 : model_pop(v, c, mp, hl);
    got_pop = int'(pop);
    chk("pop_cnt", 64'(pop), 64'(ep));
    if (rst) begin
      m_recov = 0; m_halted = 1'b0; m_cnt = 0; e_cv = '0;
    end else begin
      for (int i = 0; i < W; i++) e_cv[i] = (i < ep) && hd[i];
      e_arch = a; e_phys = p; e_old = op;
      m_cnt = (m_cnt + ep) % (1 << CNT_W);
      if (m_recov > 0) m_recov--;
      else if (ep > 0) begin
        if (mp[ep-1])      m_recov = 2;
        else if (hl[ep-1]) m_halted = 1'b1;
      end
    end
    @(posedge clock); #1;
    chk("commit_valid", 64'(commit_valid), 64'(e_cv));
    chk("free_valid", 64'(free_valid), 64'(e_cv));
    chk("flush", 64'(flush), 64'(m_recov == 1));
    chk("halt", 64'(halted), 64'(m_halted));
    chk("count", 64'(count), 64'(m_cnt));
    for (int i = 0; i < W; i++) if (e_cv[i]) begin
      chk("commit_arch", 64'(commit_arch[i]), 64'(e_arch[i]));
      chk("commit_phys", 64'(commit_phys[i]), 64'(e_phys[i]));
      chk("free_phys", 64'(free_phys[i]), 64'(e_old[i]));
    end
  endtask

  typedef struct {
    logic [W-1:0]          v, c, hd;
    logic [W-1:0][AW-1:0]  a;
    logic [W-1:0][PWD-1:0] p, op;
    int                    pop;
    logic [W-1:0]          cv;
  } vec_t;

  vec_t tab[7];

  initial begin
    int gp;
    logic [W-1:0] z;
    logic [W-1:0][AW-1:0]  za;
    logic [W-1:0][PWD-1:0] zp;
    logic [W-1:0] rv, rc, rhd, rmp, rhl;
    logic [W-1:0][AW-1:0]  ra;
    logic [W-1:0][PWD-1:0] rp, rop;
    logic rrst;

    z = '0; za = '0; zp = '0;
    tab[0] = '{v:2'b11, c:2'b11, hd:2'b11, a:{6'd5, 6'd3}, p:{7'd71, 7'd70}, op:{7'd5, 7'd3}, pop:2, cv:2'b11};
    tab[1] = '{v:2'b11, c:2'b10, hd:2'b11, a:{6'd9, 6'd8}, p:{7'd81, 7'd80}, op:{7'd9, 7'd8}, pop:0, cv:2'b00};
    tab[2] = '{v:2'b11, c:2'b11, hd:2'b11, a:{6'd9, 6'd8}, p:{7'd81, 7'd80}, op:{7'd9, 7'd8}, pop:2, cv:2'b11};
    tab[3] = '{v:2'b01, c:2'b01, hd:2'b00, a:{6'd0, 6'd1}, p:{7'd0, 7'd2}, op:{7'd0, 7'd3}, pop:1, cv:2'b00};
    tab[4] = '{v:2'b00, c:2'b11, hd:2'b11, a:{6'd1, 6'd1}, p:{7'd1, 7'd1}, op:{7'd1, 7'd1}, pop:0, cv:2'b00};
    tab[5] = '{v:2'b11, c:2'b11, hd:2'b10, a:{6'd63, 6'd4}, p:{7'd127, 7'd99}, op:{7'd64, 7'd4}, pop:2, cv:2'b10};
    tab[6] = '{v:2'b10, c:2'b10, hd:2'b11, a:{6'd2, 6'd2}, p:{7'd2, 7'd2}, op:{7'd2, 7'd2}, pop:0, cv:2'b00};

    reset = 1'b1; valid = '0; complete = '0; has_dest = '0; mispred = '0; halt = '0;
    arch = '0; phys = '0; old_phys = '0;
    @(posedge clock); #1;

    // Reset held two cycles, then released with an empty ROB.
    cycle(1'b1, z, z, z, z, z, za, zp, zp, gp);
    cycle(1'b1, z, z, z, z, z, za, zp, zp, gp);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    cycle(1'b0, z, z, z, z, z, za, zp, zp, gp);
    cycle(1'b0, z, z, z, z, z, za, zp, zp, gp);
    chk("empty_pop", 64'(gp), 64'd0);

    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, tab[i].v, tab[i].c, tab[i].hd, z, z, tab[i].a, tab[i].p, tab[i].op, gp);
      chk("tab_pop", 64'(gp), 64'(tab[i].pop));
      chk("tab_cv", 64'(commit_valid), 64'(tab[i].cv));
      if (i == 0) begin
        chk("tab0_free_phys", 64'(free_phys), 64'({7'd5, 7'd3}));
        chk("tab0_count", 64'(count), 64'd2);
      end
    end

    // Mispredicted branch in slot 0: slot 1 must not retire; DRAIN, FLUSH, then RUN.
    cycle(1'b0, 2'b11, 2'b11, 2'b10, 2'b01, z, {6'd12, 6'd0}, {7'd100, 7'd0}, {7'd12, 7'd0}, gp);
    chk("mis_pop", 64'(gp), 64'd1);
    chk("mis_cv", 64'(commit_valid), 64'd0);
    chk("drain_flush", 64'(flush), 64'd0);
    cycle(1'b0, 2'b11, 2'b11, 2'b10, 2'b01, z, {6'd12, 6'd0}, {7'd100, 7'd0}, {7'd12, 7'd0}, gp);
    chk("drain_pop", 64'(gp), 64'd0);
    chk("flush_hi", 64'(flush), 64'd1);
    cycle(1'b0, 2'b11, 2'b11, 2'b11, z, z, {6'd13, 6'd12}, {7'd101, 7'd100}, {7'd13, 7'd12}, gp);
    chk("flush_pop", 64'(gp), 64'd0);
    chk("flush_lo", 64'(flush), 64'd0);
    cycle(1'b0, 2'b11, 2'b11, 2'b11, z, z, {6'd13, 6'd12}, {7'd101, 7'd100}, {7'd13, 7'd12}, gp);
    chk("resume_pop", 64'(gp), 64'd2);

    // r7->p90 then halt: both pop, halt sticky, nothing retires afterwards.
    cycle(1'b0, 2'b11, 2'b11, 2'b01, z, 2'b10, {6'd0, 6'd7}, {7'd0, 7'd90}, {7'd0, 7'd7}, gp);
    chk("halt_pop", 64'(gp), 64'd2);
    chk("halt_o", 64'(halted), 64'd1);
    chk("halt_cv", 64'(commit_valid), 64'd1);
    chk("halt_arch", 64'(commit_arch[0]), 64'd7);
    chk("halt_phys", 64'(commit_phys[0]), 64'd90);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'b11, 2'b11, 2'b11, z, z, {6'd1, 6'd2}, {7'd3, 7'd4}, {7'd5, 7'd6}, gp);
      chk("halted_pop", 64'(gp), 64'd0);
      chk("halted_sticky", 64'(halted), 64'd1);
    end

    // Reset arriving while in FLUSH, then wrap the counter.
    cycle(1'b1, z, z, z, z, z, za, zp, zp, gp);
    cycle(1'b0, 2'b01, 2'b01, z, 2'b01, z, za, zp, zp, gp);
    cycle(1'b0, z, z, z, z, z, za, zp, zp, gp);
    chk("pre_rst_flush", 64'(flush), 64'd1);
    cycle(1'b1, z, z, z, z, z, za, zp, zp, gp);
    chk("rst_in_flush", 64'(flush), 64'd0);
    chk("rst_in_flush_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 33; i++)
      cycle(1'b0, 2'b11, 2'b11, 2'b11, z, z, {6'd21, 6'd20}, {7'd41, 7'd40}, {7'd21, 7'd20}, gp);
    chk("wrap_count", 64'(count), 64'd2);

    for (int n = 0; n < 600; n++) begin
      rrst = ($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      for (int i = 0; i < W; i++) begin
        rv[i]  = ($urandom_range(0, 7) != 0);
        rc[i]  = ($urandom_range(0, 3) != 0);
        rhd[i] = $urandom_range(0, 1) != 0;
        rmp[i] = ($urandom_range(0, 7) == 0);
        rhl[i] = ($urandom_range(0, 39) == 0);
      end
      ra = AV'($urandom); rp = PV'($urandom); rop = PV'($urandom);
      cycle(rrst, rv, rc, rhd, rmp, rhl, ra, rp, rop, gp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
